// File: rtl/fifo_wr_arbiter.sv
// Write-side scheduler for the async FIFO write port.
// Round-robin arbitration between NUM_REQ requesters. Each grant covers one
// burst of up to BURST_MAX words, and the burst stalls while the FIFO is full.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_MAX  = 4
) (
  input  logic                          wclk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic                          full,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);
  localparam logic [IDX_W-1:0] IDX_INIT = IDX_W'(NUM_REQ - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   gidx_q,  gidx_d;
  logic [IDX_W-1:0]   last_q,  last_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  int unsigned        cand;
  logic               in_burst;
  logic               req_g;
  logic               last_g;
  logic               xfer;

  // Granted requester's request/last, and the transfer qualifier.
  // Reset gates the strobe so no word is acked (and lost) in a reset cycle.
  assign in_burst = (state_q == S_BURST);
  assign req_g    = req[gidx_q];
  assign last_g   = req_last[gidx_q];
  assign xfer     = in_burst & req_g & ~full & ~rst;

  // Round-robin pick: first set request searching from last+1, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = 32'(last_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!sel_found && req[IDX_W'(cand)]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(cand);
      end
    end
  end

  // State register: synchronous reset returns to IDLE with requester 0 first.
  always_ff @(posedge wclk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IDX_INIT;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  // Next-state: grant in IDLE, count words in BURST, end on last/limit/drop.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    count_d = count_q;
    unique case (state_q)
      S_IDLE: begin
        grant_d = '0;
        if (sel_found) begin
          state_d = S_BURST;
          grant_d = NUM_REQ'(1) << sel_idx;
          gidx_d  = sel_idx;
          last_d  = sel_idx;
          count_d = '0;
        end
      end
      S_BURST: begin
        if (xfer) begin
          count_d = count_q + CNT_W'(1);
          if (last_g || (count_q == CNT_LAST)) begin
            state_d = S_IDLE;
            grant_d = '0;
          end
        end else if (!req_g) begin
          // Requester withdrew before its next word: release the port.
          state_d = S_IDLE;
          grant_d = '0;
        end
      end
    endcase
  end

  // Outputs: write strobe, one-hot ack and data mux for the granted requester.
  always_comb begin
    busy  = in_burst & ~rst;
    winc  = xfer;
    ack   = {NUM_REQ{xfer}} & grant_q;
    grant = grant_q;
    wdata = '0;
    if (busy) begin
      wdata = req_data[32'(gidx_q) * DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: per-cycle vector table followed by
// source-driven sequences whose written words are checked by a scoreboard.
module tb_fifo_wr_arbiter;

  localparam int unsigned NR    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 32;

  logic              wclk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_last;
  logic              full;
  logic [NR-1:0]     ack;
  logic              winc;
  logic [DW-1:0]     wdata;
  logic [NR-1:0]     grant;
  logic              busy;

  fifo_wr_arbiter #(
    .NUM_REQ   (NR),
    .DATA_WIDTH(DW),
    .BURST_MAX (4)
  ) dut (
    .wclk    (wclk),
    .rst     (rst),
    .req     (req),
    .req_data(req_data),
    .req_last(req_last),
    .full    (full),
    .ack     (ack),
    .winc    (winc),
    .wdata   (wdata),
    .grant   (grant),
    .busy    (busy)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic [NR-1:0]    req;
    logic [NR*DW-1:0] data;
    logic [NR-1:0]    last;
    logic             full;
    logic [NR-1:0]    e_grant;
    logic             e_busy;
    logic             e_winc;
    logic [DW-1:0]    e_wdata;
    logic [NR-1:0]    e_ack;
  } vec_t;

  vec_t vecs [13];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_wr    = 0;
  int first_wr = -1;
  int last_wr  = -1;

  logic          full_r;
  logic [DW-1:0] src_data [NR][DEPTH];
  logic          src_last [NR][DEPTH];
  int            src_len  [NR];
  int            src_ptr  [NR];

  logic [DW-1:0] exp_d [$];
  int            exp_who [$];

  logic          s_winc;
  logic [NR-1:0] s_ack;
  logic [DW-1:0] s_wdata;
  logic [NR-1:0] s_grant;
  logic          s_busy;

  function automatic vec_t mk(input logic [NR-1:0] r, input logic [NR*DW-1:0] d,
                              input logic [NR-1:0] l, input logic f,
                              input logic [NR-1:0] eg, input logic eb, input logic ew,
                              input logic [DW-1:0] ed, input logic [NR-1:0] ea);
    vec_t v;
    v.req = r; v.data = d; v.last = l; v.full = f;
    v.e_grant = eg; v.e_busy = eb; v.e_winc = ew; v.e_wdata = ed; v.e_ack = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add_word(input int i, input logic [DW-1:0] d, input logic l);
    src_data[i][src_len[i]] = d;
    src_last[i][src_len[i]] = l;
    src_len[i]++;
  endtask

  task automatic expect_word(input int w, input logic [DW-1:0] d);
    exp_d.push_back(d);
    exp_who.push_back(w);
  endtask

  task automatic sample_and_score();
    logic [DW-1:0] d;
    int            w;
    s_winc  = winc;
    s_ack   = ack;
    s_wdata = wdata;
    s_grant = grant;
    s_busy  = busy;
    if (full) chk("winc_while_full", 32'(winc), 32'(0));
    if (!winc) begin
      chk("ack_without_winc", 32'(ack), 32'(0));
    end else if (exp_d.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_extra_write: wdata 0x%0h ack 0x%0h with no word expected (cycle %0d)",
               wdata, ack, cyc);
    end else begin
      d = exp_d.pop_front();
      w = exp_who.pop_front();
      chk("sb_wdata", 32'(wdata), 32'(d));
      chk("sb_ack",   32'(ack),   32'(1) << w);
      chk("sb_grant", 32'(grant), 32'(1) << w);
      n_wr++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
    end
  endtask

  // One clock: drive requesters from their sources, sample, retire acked words.
  task automatic cycle();
    for (int i = 0; i < NR; i++) begin
      if (src_ptr[i] < src_len[i]) begin
        req[i]              = 1'b1;
        req_data[i*DW +: DW] = src_data[i][src_ptr[i]];
        req_last[i]         = src_last[i][src_ptr[i]];
      end else begin
        req[i]              = 1'b0;
        req_data[i*DW +: DW] = '0;
        req_last[i]         = 1'b0;
      end
    end
    full = full_r;
    #4;
    sample_and_score();
    for (int i = 0; i < NR; i++) begin
      if (s_ack[i]) src_ptr[i]++;
    end
    @(posedge wclk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    full_r = 1'b0;
    for (int i = 0; i < NR; i++) begin
      src_len[i] = 0;
      src_ptr[i] = 0;
    end
    exp_d.delete();
    exp_who.delete();
    cycle();
    cycle();
    chk("rst_grant", 32'(s_grant), 32'(0));
    chk("rst_busy",  32'(s_busy),  32'(0));
    chk("rst_winc",  32'(s_winc),  32'(0));
    rst      = 1'b0;
    n_wr     = 0;
    first_wr = -1;
    last_wr  = -1;
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while (exp_d.size() != 0 && k < budget) begin
      cycle();
      k++;
    end
    repeat (4) cycle();
    chk(name, 32'(exp_d.size()), 32'(0));
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    req      = v.req;
    req_data = v.data;
    req_last = v.last;
    full     = v.full;
    #4;
    chk($sformatf("vec%0d_grant", idx), 32'(grant), 32'(v.e_grant));
    chk($sformatf("vec%0d_busy",  idx), 32'(busy),  32'(v.e_busy));
    chk($sformatf("vec%0d_winc",  idx), 32'(winc),  32'(v.e_winc));
    chk($sformatf("vec%0d_wdata", idx), 32'(wdata), 32'(v.e_wdata));
    chk($sformatf("vec%0d_ack",   idx), 32'(ack),   32'(v.e_ack));
    @(posedge wclk);
    #1;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //              req      data          last     f  grant    b  w  wdata  ack
    vecs[0]  = mk(4'b0001, 32'h000000A1, 4'b0000, 0, 4'b0000, 0, 0, 8'h00, 4'b0000);
    vecs[1]  = mk(4'b0001, 32'h000000A1, 4'b0000, 0, 4'b0001, 1, 1, 8'hA1, 4'b0001);
    vecs[2]  = mk(4'b0001, 32'h000000A2, 4'b0000, 0, 4'b0001, 1, 1, 8'hA2, 4'b0001);
    vecs[3]  = mk(4'b0001, 32'h000000A3, 4'b0001, 0, 4'b0001, 1, 1, 8'hA3, 4'b0001);
    vecs[4]  = mk(4'b0000, 32'h00000000, 4'b0000, 0, 4'b0000, 0, 0, 8'h00, 4'b0000);
    vecs[5]  = mk(4'b0010, 32'h0000B100, 4'b0000, 0, 4'b0000, 0, 0, 8'h00, 4'b0000);
    vecs[6]  = mk(4'b0000, 32'h00000000, 4'b0000, 0, 4'b0010, 1, 0, 8'h00, 4'b0000);
    vecs[7]  = mk(4'b0100, 32'h00C10000, 4'b0100, 0, 4'b0000, 0, 0, 8'h00, 4'b0000);
    vecs[8]  = mk(4'b0100, 32'h00C10000, 4'b0100, 1, 4'b0100, 1, 0, 8'hC1, 4'b0000);
    vecs[9]  = mk(4'b0101, 32'h00C1005A, 4'b0101, 0, 4'b0100, 1, 1, 8'hC1, 4'b0100);
    vecs[10] = mk(4'b0001, 32'h0000005A, 4'b0001, 0, 4'b0000, 0, 0, 8'h00, 4'b0000);
    vecs[11] = mk(4'b0001, 32'h0000005A, 4'b0001, 0, 4'b0001, 1, 1, 8'h5A, 4'b0001);
    vecs[12] = mk(4'b0000, 32'h00000000, 4'b0000, 0, 4'b0000, 0, 0, 8'h00, 4'b0000);

    // Per-cycle vectors: short burst, dropped grant, full on last word.
    do_reset();
    for (int i = 0; i < 13; i++) apply_vec(vecs[i], i);

    // req0 and req2 held without last: bursts capped at 4, one idle between.
    do_reset();
    for (int k = 0; k < 8; k++) add_word(0, 8'(k), 1'b0);
    for (int k = 0; k < 4; k++) add_word(2, 8'(8'h20 + k), 1'b0);
    for (int k = 0; k < 4; k++) expect_word(0, 8'(k));
    for (int k = 0; k < 4; k++) expect_word(2, 8'(8'h20 + k));
    for (int k = 4; k < 8; k++) expect_word(0, 8'(k));
    drain("t2_drain", 60);
    chk("t2_words", 32'(n_wr), 32'(12));
    chk("t2_span",  32'(last_wr - first_wr + 1), 32'(14));

    // Full asserted for 5 cycles after two words of a burst.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      add_word(0, 8'(8'hB0 + k), 1'b0);
      expect_word(0, 8'(8'hB0 + k));
    end
    for (int k = 0; k < 10 && n_wr < 2; k++) cycle();
    chk("t3_pre_words", 32'(n_wr), 32'(2));
    full_r = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t3_stall_winc",  32'(s_winc),  32'(0));
      chk("t3_stall_ack",   32'(s_ack),   32'(0));
      chk("t3_stall_grant", 32'(s_grant), 32'(4'b0001));
    end
    full_r = 1'b0;
    cycle();
    chk("t3_resume_winc",  32'(s_winc),  32'(1));
    chk("t3_resume_wdata", 32'(s_wdata), 32'(8'hB2));
    drain("t3_drain", 20);
    chk("t3_words", 32'(n_wr), 32'(4));

    // All four requesting single-word bursts: strict rotation 0,1,2,3,0,...
    do_reset();
    for (int i = 0; i < NR; i++) begin
      for (int k = 0; k < 2; k++) add_word(i, 8'(8'h40 + i * 16 + k), 1'b1);
    end
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NR; i++) expect_word(i, 8'(8'h40 + i * 16 + k));
    end
    drain("t4_drain", 60);
    chk("t4_words", 32'(n_wr), 32'(8));
    chk("t4_span",  32'(last_wr - first_wr + 1), 32'(15));

    // Reset pulsed during the second word of a burst.
    do_reset();
    for (int k = 0; k < 4; k++) add_word(0, 8'(8'hE0 + k), 1'b0);
    add_word(1, 8'hF0, 1'b0);
    add_word(1, 8'hF1, 1'b1);
    for (int k = 0; k < 4; k++) expect_word(0, 8'(8'hE0 + k));
    expect_word(1, 8'hF0);
    expect_word(1, 8'hF1);
    for (int k = 0; k < 10 && n_wr < 1; k++) cycle();
    chk("t6_pre_words", 32'(n_wr), 32'(1));
    rst = 1'b1;
    cycle();
    chk("t6_rst_winc", 32'(s_winc), 32'(0));
    chk("t6_rst_busy", 32'(s_busy), 32'(0));
    rst = 1'b0;
    cycle();
    chk("t6_post_grant", 32'(s_grant), 32'(0));
    chk("t6_post_busy",  32'(s_busy),  32'(0));
    chk("t6_post_winc",  32'(s_winc),  32'(0));
    cycle();
    chk("t6_rearb_grant", 32'(s_grant), 32'(4'b0001));
    drain("t6_drain", 40);
    chk("t6_words", 32'(n_wr), 32'(6));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
